// File: rtl/rc_adder_pkg.sv
// Shared constants and types for the round-robin front end of a pipelined ripple-carry adder.
package rc_adder_pkg;

  localparam int unsigned DefWidth = 64;
  localparam int unsigned DefNreq  = 4;
  localparam int unsigned DefLat   = 4;
  localparam int unsigned MaxIdw   = 16;

  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // The id field is sized for the largest supported requester count; users slice the low bits.
  typedef struct packed {
    logic              valid;
    logic [MaxIdw-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching from ptr, ptr advances past the winner.
module rr_arbiter
  import rc_adder_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned IDW  = id_width(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            gnt_valid_o,
  output logic [IDW-1:0]  gnt_id_o
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           found;
  logic [IDW-1:0] found_id;

  always_comb begin
    found    = 1'b0;
    found_id = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      int unsigned idx;
      idx = (32'(ptr_q) + k) % NREQ;
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        found_id = IDW'(idx);
      end
    end
  end

  // Grants are suppressed while reset is held so no handshake can be observed by requesters.
  always_comb begin
    gnt_valid_o = found & ~rst_i;
    gnt_id_o    = found_id;
    gnt_o       = gnt_valid_o ? (NREQ'(1) << found_id) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o) begin
      ptr_d = (found_id == IDW'(NREQ - 1)) ? '0 : IDW'(found_id + 1'b1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rc_adder_arbiter.sv
// Shares one external fixed-latency adder between NREQ requesters; results return tagged
// with the owning requester ID via a tag pipeline matched to the adder latency.
module rc_adder_arbiter
  import rc_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned NREQ  = DefNreq,
  parameter int unsigned LAT   = DefLat,
  parameter int unsigned IDW   = id_width(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      add_a,
  output logic [WIDTH-1:0]      add_b,
  output logic                  add_cin,
  input  logic [WIDTH-1:0]      add_sum,
  input  logic                  add_cout,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH-1:0]      res_sum,
  output logic                  res_cout,
  output logic                  busy
);

  logic [NREQ-1:0] gnt;
  logic            gnt_valid;
  logic [IDW-1:0]  gnt_id;

  rr_arbiter #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_arb (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req_valid),
    .gnt_o      (gnt),
    .gnt_valid_o(gnt_valid),
    .gnt_id_o   (gnt_id)
  );

  assign req_ready = gnt;

  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             add_cin_q, add_cin_d;
  tag_t             issue_d;

  always_comb begin
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    add_cin_d = add_cin_q;
    issue_d   = '0;
    if (gnt_valid) begin
      add_a_d           = req_a[32'(gnt_id) * WIDTH +: WIDTH];
      add_b_d           = req_b[32'(gnt_id) * WIDTH +: WIDTH];
      add_cin_d         = req_cin[gnt_id];
      issue_d.valid     = 1'b1;
      issue_d.id[IDW-1:0] = gnt_id;
    end
  end

  // tag_q[0] is the issue register; tag_q[LAT] lines up with add_sum.
  tag_t tag_q [LAT+1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_cin_q <= 1'b0;
      for (int unsigned k = 0; k <= LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_cin_q <= add_cin_d;
      tag_q[0]  <= issue_d;
      for (int unsigned k = 1; k <= LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign add_a   = add_a_q;
  assign add_b   = add_b_q;
  assign add_cin = add_cin_q;

  logic             res_valid_q;
  logic [IDW-1:0]   res_id_q;
  logic [WIDTH-1:0] res_sum_q;
  logic             res_cout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_sum_q   <= '0;
      res_cout_q  <= 1'b0;
    end else begin
      res_valid_q <= tag_q[LAT].valid;
      if (tag_q[LAT].valid) begin
        res_id_q   <= tag_q[LAT].id[IDW-1:0];
        res_sum_q  <= add_sum;
        res_cout_q <= add_cout;
      end
    end
  end

  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;

  // High ID bits beyond IDW are always zero and intentionally dropped.
  logic unused_tag_id;
  assign unused_tag_id = ^tag_q[LAT].id;

  always_comb begin
    busy = 1'b0;
    for (int unsigned k = 0; k <= LAT; k++) begin
      busy = busy | tag_q[k].valid;
    end
  end

endmodule

// File: doc/rc_adder_arbiter.md
Name: rc_adder_arbiter

Overview:
Shares one pipelined ripple-carry adder (pipeline_rc_adder style: a, b, cin in; sum, cout out; fixed latency, no stall) between NREQ requesters. Round-robin arbiter grants one request per cycle and registers its operands into the adder. An ID/valid tag pipeline matched to the adder latency returns each result with its requester ID. Sits beside the adder instance in the parent; the adder itself is not instantiated here.

Parameters:
WIDTH, 64, operand/sum width
NREQ, 4, number of requesters (>=1)
LAT, 4, adder latency: add_sum/add_cout reflect add_a/add_b/add_cin sampled exactly LAT clk edges earlier (>=1)
IDW, $clog2(NREQ) (min 1), requester ID width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  NREQ  request per requester
req_a  in  NREQ*WIDTH  operand a, requester i at [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand b, same packing
req_cin  in  NREQ  carry-in per requester
req_ready  out  NREQ  one-hot grant; handshake = req_valid[i] & req_ready[i]
add_a  out  WIDTH  to adder a
add_b  out  WIDTH  to adder b
add_cin  out  1  to adder cin
add_sum  in  WIDTH  from adder sum
add_cout  in  1  from adder cout
res_valid  out  1  one-cycle result strobe
res_id  out  IDW  requester owning result
res_sum  out  WIDTH  result sum
res_cout  out  1  result carry-out
busy  out  1  any operation in flight

Behaviour:
- Reset (async assert, sync release): ptr=0, add_a/add_b/add_cin=0, tag pipeline cleared, res_valid=0, res_id=0, res_sum=0, res_cout=0, busy=0; req_ready forced 0 while rst=1.
- Grant (combinational): first i with req_valid[i]=1 searching ptr, ptr+1, ... mod NREQ; req_ready[i]=1 for that i only; all 0 if no req_valid. At most one bit set.
- Requesters hold valid and operands stable until handshake; no retraction. ready never depends on res path: no backpressure; results must be consumed on the strobe.
- On handshake at edge t: add_a/add_b/add_cin <= granted operands; issue tag {v=1,id=i}; ptr <= (i+1) mod NREQ. No handshake: add_* hold previous values, issue tag v=0, ptr unchanged.
- Tag pipeline: LAT stages after issue register; stage LAT aligns with add_sum.
- Result register: res_valid <= tag[LAT].v; when v=1 res_id/res_sum/res_cout <= tag id, add_sum, add_cout; when v=0 data holds.
- Latency: handshake edge to res_valid high = LAT+1 edges after the issue edge (LAT+2 cycles from request cycle). Throughput 1 op/cycle; back-to-back results contiguous, in issue order.
- busy = OR of issue-tag v and all tag-pipeline v bits (excludes result register).
- Width: sum is WIDTH bits mod 2^WIDTH, carry in add_cout; block does no arithmetic.
- NREQ=1: grant = req_valid[0], id always 0.
- Reset mid-flight: all tags cleared; no res_valid for ops issued before reset, regardless of adder contents.

Decomposition:
- Package rc_adder_pkg: default WIDTH/LAT constants, ID-width function, tag struct {valid, id}.
- One sub-module: rr_arbiter (NREQ-wide req in, one-hot grant out, ptr register, advance on handshake).

Test Plan:
- Single requester 2, a=5, b=200, cin=0, one handshake at cycle 0 -> req_ready=4'b0100 that cycle; res_valid exactly at LAT+2 cycles after, res_id=2, res_sum=205, res_cout=0; busy high LAT+1 cycles.
- All 4 valid continuously, ptr=0 after reset -> grants 0,1,2,3,0,1..., one per cycle; res_id sequence 0,1,2,3,... contiguous, each sum correct (bench adder model with same LAT).
- Wrap: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> res_sum=0, res_cout=1; a=b=all ones, cin=1 -> sum all ones, cout=1.
- Sparse: req 1 and 3 valid, ptr=2 -> grant 3 then 1; req 3 drops after handshake -> req 1 granted every cycle after.
- Reset mid-flight: issue 3 ops, assert rst 2 cycles later for 1 cycle -> outputs zero immediately, no res_valid in next 2*LAT cycles, ptr=0.
- Idle: no req_valid 20 cycles -> req_ready=0, res_valid=0, busy=0, add_a/add_b hold last granted values.
